// File: rtl/trace_fmt_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : trace_fmt_pkg                                              |
// | Description : Shared definitions for the trace character emitter:       |
// |               ASCII constants of the checker line format, record kind    |
// |               encoding, emitter FSM states, legal gap width range and     |
// |               helpers for the BCD time field.                            |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package trace_fmt_pkg;

  // Punctuation characters of the checker line format
  localparam logic [7:0] CH_CARET  = 8'h5E;  // ^
  localparam logic [7:0] CH_AT     = 8'h40;  // @
  localparam logic [7:0] CH_COLON  = 8'h3A;  // :
  localparam logic [7:0] CH_DOLLAR = 8'h24;  // $
  localparam logic [7:0] CH_STAR   = 8'h2A;  // *
  localparam logic [7:0] CH_LT     = 8'h3C;  // <
  localparam logic [7:0] CH_EQ     = 8'h3D;  // =
  localparam logic [7:0] CH_HASH   = 8'h23;  // #
  localparam logic [7:0] CH_SPACE  = 8'h20;  // space

  // Record kind
  localparam logic KIND_REG = 1'b0;
  localparam logic KIND_MEM = 1'b1;

  // Legal number of spaces per gap
  localparam int SP_N_MIN = 0;
  localparam int SP_N_MAX = 3;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_CARET = 4'd1,
    ST_TIME  = 4'd2,
    ST_AT    = 4'd3,
    ST_PC    = 4'd4,
    ST_COLON = 4'd5,
    ST_GAP1  = 4'd6,
    ST_TAG   = 4'd7,
    ST_REG   = 4'd8,
    ST_ADDR  = 4'd9,
    ST_GAP2  = 4'd10,
    ST_LT    = 4'd11,
    ST_EQ    = 4'd12,
    ST_GAP3  = 4'd13,
    ST_DATA  = 4'd14,
    ST_HASH  = 4'd15
  } state_t;

  // True when every nibble of the time field is a decimal digit
  function automatic logic bcd_ok(input logic [15:0] t);
    return (t[15:12] <= 4'd9) && (t[11:8] <= 4'd9) &&
           (t[7:4]   <= 4'd9) && (t[3:0]  <= 4'd9);
  endfunction

  // Index of the most significant non-zero digit; 0 when the value is zero
  // so that a single "0" is still emitted.
  function automatic logic [1:0] time_msd(input logic [15:0] t);
    if (t[15:12] != 4'd0)     return 2'd3;
    else if (t[11:8] != 4'd0) return 2'd2;
    else if (t[7:4] != 4'd0)  return 2'd1;
    else                      return 2'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trace_char_emitter_if.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : trace_char_emitter_if                                      |
// | Description : Writeback record handshake bus. The master (writeback      |
// |               monitor) offers a record with in_valid and holds the       |
// |               fields stable; the slave (emitter) accepts with in_ready.  |
// |   in_valid/in_ready : handshake                                          |
// |   in_kind           : 0 register write, 1 memory write                   |
// |   in_time           : 4 BCD digits                                       |
// |   in_pc/in_addr/in_data : 32-bit hex fields, in_reg : 5-bit register     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface trace_char_emitter_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_kind;
  logic [15:0] in_time;
  logic [31:0] in_pc;
  logic [4:0]  in_reg;
  logic [31:0] in_addr;
  logic [31:0] in_data;

  modport master (
    output in_valid, in_kind, in_time, in_pc, in_reg, in_addr, in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_kind, in_time, in_pc, in_reg, in_addr, in_data,
    output in_ready
  );
endinterface
`default_nettype wire

// File: rtl/nibble_to_ascii.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : nibble_to_ascii                                            |
// | Description : Combinational 4-bit to lowercase hex ASCII. Also used for  |
// |               decimal digits, which map onto '0'..'9'.                   |
// |   nibble : input value 0..15                                             |
// |   ascii  : '0'..'9', 'a'..'f'                                            |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module nibble_to_ascii (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);
  // 8'h57 + 10 = 'a'
  always_comb begin
    if (nibble < 4'd10) ascii = 8'h30 + {4'h0, nibble};
    else                ascii = 8'h57 + {4'h0, nibble};
  end
endmodule
`default_nettype wire

// File: rtl/trace_char_emitter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : trace_char_emitter                                         |
// | Description : Serialises one writeback record per handshake into the    |
// |               checker line format, one character per clock:              |
// |                 ^<time>@<pc>: $<reg> <= <data>#                          |
// |                 ^<time>@<pc>: *<addr> <= <data>#                         |
// |   clk, reset : clock, synchronous active-high reset                      |
// |   rec        : record handshake bus (slave side)                         |
// |   char       : registered output character, IDLE_CHAR when idle          |
// |   char_valid : high while char carries a record character                |
// |   err        : one-cycle pulse when an accepted record had bad BCD time  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module trace_char_emitter
  import trace_fmt_pkg::*;
#(
  parameter int         SP_N      = 1,
  parameter logic [7:0] IDLE_CHAR = 8'h20
) (
  input  logic                 clk,
  input  logic                 reset,
  trace_char_emitter_if.slave  rec,
  output logic [7:0]           char,
  output logic                 char_valid,
  output logic                 err
);

  // Out-of-range gap widths are clamped into the legal range
  localparam int SP_EFF = (SP_N < SP_N_MIN) ? SP_N_MIN :
                          (SP_N > SP_N_MAX) ? SP_N_MAX : SP_N;
  localparam bit         HAS_GAP = (SP_EFF != 0);
  localparam logic [1:0] SP_LAST = HAS_GAP ? 2'(SP_EFF - 1) : 2'd0;

  state_t      state, nxt_state;
  logic [2:0]  idx, nxt_idx;      // digit index, counts down to 0
  logic [1:0]  sp, nxt_sp;        // remaining spaces in the current gap
  logic        kind_q;
  logic [15:0] time_q;
  logic [31:0] pc_q;
  logic [4:0]  reg_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [1:0]  msd_q;

  logic        accept;
  logic        time_ok;
  logic        reg_two;
  logic [3:0]  reg_tens;
  logic [3:0]  reg_ones;
  logic [3:0]  nxt_nibble;
  logic [7:0]  hex_char;
  logic [7:0]  nxt_char;

  assign rec.in_ready = (state == ST_IDLE) || (state == ST_HASH);
  assign accept       = rec.in_valid && rec.in_ready;
  assign time_ok      = bcd_ok(rec.in_time);

  // Decimal split of the register number. The ones digit is always < 10, so
  // it can be formed modulo 16 from the low nibbles alone
  // (10 -> 4'd10, 20 -> 4'd4, 30 -> 4'd14).
  always_comb begin
    if (reg_q >= 5'd30) begin
      reg_tens = 4'd3;
      reg_ones = reg_q[3:0] - 4'd14;
    end else if (reg_q >= 5'd20) begin
      reg_tens = 4'd2;
      reg_ones = reg_q[3:0] - 4'd4;
    end else if (reg_q >= 5'd10) begin
      reg_tens = 4'd1;
      reg_ones = reg_q[3:0] - 4'd10;
    end else begin
      reg_tens = 4'd0;
      reg_ones = reg_q[3:0];
    end
  end
  assign reg_two = (reg_q >= 5'd10);

  // Next-state, digit index and space counter
  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    nxt_sp    = sp;
    case (state)
      ST_IDLE: begin
        if (accept && time_ok) nxt_state = ST_CARET;
      end
      ST_CARET: begin
        nxt_state = ST_TIME;
        nxt_idx   = {1'b0, msd_q};
      end
      ST_TIME: begin
        if (idx == 3'd0) nxt_state = ST_AT;
        else             nxt_idx   = idx - 3'd1;
      end
      ST_AT: begin
        nxt_state = ST_PC;
        nxt_idx   = 3'd7;
      end
      ST_PC: begin
        if (idx == 3'd0) nxt_state = ST_COLON;
        else             nxt_idx   = idx - 3'd1;
      end
      ST_COLON: begin
        if (HAS_GAP) begin
          nxt_state = ST_GAP1;
          nxt_sp    = SP_LAST;
        end else begin
          nxt_state = ST_TAG;
        end
      end
      ST_GAP1: begin
        if (sp == 2'd0) nxt_state = ST_TAG;
        else            nxt_sp    = sp - 2'd1;
      end
      ST_TAG: begin
        if (kind_q == KIND_MEM) begin
          nxt_state = ST_ADDR;
          nxt_idx   = 3'd7;
        end else begin
          nxt_state = ST_REG;
          nxt_idx   = {2'b00, reg_two};
        end
      end
      ST_REG, ST_ADDR: begin
        if (idx == 3'd0) begin
          if (HAS_GAP) begin
            nxt_state = ST_GAP2;
            nxt_sp    = SP_LAST;
          end else begin
            nxt_state = ST_LT;
          end
        end else begin
          nxt_idx = idx - 3'd1;
        end
      end
      ST_GAP2: begin
        if (sp == 2'd0) nxt_state = ST_LT;
        else            nxt_sp    = sp - 2'd1;
      end
      ST_LT: nxt_state = ST_EQ;
      ST_EQ: begin
        if (HAS_GAP) begin
          nxt_state = ST_GAP3;
          nxt_sp    = SP_LAST;
        end else begin
          nxt_state = ST_DATA;
          nxt_idx   = 3'd7;
        end
      end
      ST_GAP3: begin
        if (sp == 2'd0) begin
          nxt_state = ST_DATA;
          nxt_idx   = 3'd7;
        end else begin
          nxt_sp = sp - 2'd1;
        end
      end
      ST_DATA: begin
        if (idx == 3'd0) nxt_state = ST_HASH;
        else             nxt_idx   = idx - 3'd1;
      end
      ST_HASH: begin
        // A handshake on the '#' cycle chains straight into the next record
        nxt_state = (accept && time_ok) ? ST_CARET : ST_IDLE;
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  // Digit for the character that will be shown in the next state
  always_comb begin
    nxt_nibble = 4'd0;
    case (nxt_state)
      ST_TIME: nxt_nibble = time_q[{nxt_idx[1:0], 2'b00} +: 4];
      ST_PC:   nxt_nibble = pc_q[{nxt_idx, 2'b00} +: 4];
      ST_ADDR: nxt_nibble = addr_q[{nxt_idx, 2'b00} +: 4];
      ST_DATA: nxt_nibble = data_q[{nxt_idx, 2'b00} +: 4];
      ST_REG:  nxt_nibble = nxt_idx[0] ? reg_tens : reg_ones;
      default: nxt_nibble = 4'd0;
    endcase
  end

  nibble_to_ascii u_hex (
    .nibble (nxt_nibble),
    .ascii  (hex_char)
  );

  always_comb begin
    nxt_char = IDLE_CHAR;
    case (nxt_state)
      ST_IDLE:                          nxt_char = IDLE_CHAR;
      ST_CARET:                         nxt_char = CH_CARET;
      ST_AT:                            nxt_char = CH_AT;
      ST_COLON:                         nxt_char = CH_COLON;
      ST_GAP1, ST_GAP2, ST_GAP3:        nxt_char = CH_SPACE;
      ST_TAG:                           nxt_char = (kind_q == KIND_REG) ? CH_DOLLAR : CH_STAR;
      ST_LT:                            nxt_char = CH_LT;
      ST_EQ:                            nxt_char = CH_EQ;
      ST_HASH:                          nxt_char = CH_HASH;
      ST_TIME, ST_PC, ST_REG,
      ST_ADDR, ST_DATA:                 nxt_char = hex_char;
      default:                          nxt_char = IDLE_CHAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= 3'd0;
      sp         <= 2'd0;
      char       <= IDLE_CHAR;
      char_valid <= 1'b0;
      err        <= 1'b0;
      kind_q     <= KIND_REG;
      time_q     <= 16'd0;
      pc_q       <= 32'd0;
      reg_q      <= 5'd0;
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
      msd_q      <= 2'd0;
    end else begin
      state      <= nxt_state;
      idx        <= nxt_idx;
      sp         <= nxt_sp;
      char       <= nxt_char;
      char_valid <= (nxt_state != ST_IDLE);
      err        <= accept && !time_ok;
      if (accept) begin
        kind_q <= rec.in_kind;
        time_q <= rec.in_time;
        pc_q   <= rec.in_pc;
        reg_q  <= rec.in_reg;
        addr_q <= rec.in_addr;
        data_q <= rec.in_data;
        msd_q  <= time_msd(rec.in_time);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trace_char_emitter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : tb_trace_char_emitter                                      |
// | Description : Directed self-checking bench. Instance A uses SP_N=1,      |
// |               instance B uses SP_N=0; both share clock and reset.        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_trace_char_emitter;

  logic       clk;
  logic       reset;
  logic [7:0] char_a, char_b;
  logic       cv_a, cv_b, err_a, err_b;
  int         checks;
  int         failures;

  trace_char_emitter_if ifa ();
  trace_char_emitter_if ifb ();

  trace_char_emitter #(.SP_N(1), .IDLE_CHAR(8'h20)) u_dut_a (
    .clk        (clk),
    .reset      (reset),
    .rec        (ifa),
    .char       (char_a),
    .char_valid (cv_a),
    .err        (err_a)
  );

  trace_char_emitter #(.SP_N(0), .IDLE_CHAR(8'h20)) u_dut_b (
    .clk        (clk),
    .reset      (reset),
    .rec        (ifb),
    .char       (char_b),
    .char_valid (cv_b),
    .err        (err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] get_char(input bit sel);
    return sel ? char_b : char_a;
  endfunction

  function automatic logic get_cv(input bit sel);
    return sel ? cv_b : cv_a;
  endfunction

  function automatic logic get_ready(input bit sel);
    return sel ? ifb.in_ready : ifa.in_ready;
  endfunction

  task automatic set_rec(input bit sel, input bit kind, input logic [15:0] t,
                         input logic [31:0] pc, input logic [4:0] r,
                         input logic [31:0] a, input logic [31:0] d);
    if (sel) begin
      ifb.in_kind = kind; ifb.in_time = t; ifb.in_pc = pc;
      ifb.in_reg = r; ifb.in_addr = a; ifb.in_data = d;
    end else begin
      ifa.in_kind = kind; ifa.in_time = t; ifa.in_pc = pc;
      ifa.in_reg = r; ifa.in_addr = a; ifa.in_data = d;
    end
  endtask

  task automatic set_valid(input bit sel, input bit v);
    if (sel) ifb.in_valid = v;
    else     ifa.in_valid = v;
  endtask

  // Offer the record already on the bus; returns after the accepting edge
  task automatic send(input bit sel, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    set_valid(sel, 1'b1);
    for (int i = 0; i < 50; i++) begin
      if (get_ready(sel)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    set_valid(sel, 1'b0);
  endtask

  // Gather one line up to '#'; lead counts idle cycles before the first char
  task automatic collect(input bit sel, output string s, output int n, output int lead);
    s = "";
    n = 0;
    lead = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (get_cv(sel)) begin
        s = $sformatf("%s%c", s, get_char(sel));
        n++;
        if (get_char(sel) == 8'h23) break;
      end else if (n == 0) begin
        lead++;
      end else begin
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (char_a !== 8'h20) begin failures++; $display("FAIL reset_char_a got=%h exp=20", char_a); end
    checks++;
    if (cv_a !== 1'b0 || err_a !== 1'b0) begin failures++; $display("FAIL reset_flags_a got cv=%b err=%b exp 0 0", cv_a, err_a); end
    checks++;
    if (ifa.in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_a got=%b exp=1", ifa.in_ready); end
    checks++;
    if (char_b !== 8'h20 || cv_b !== 1'b0 || err_b !== 1'b0 || ifb.in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_b got char=%h cv=%b err=%b rdy=%b exp 20 0 0 1", char_b, cv_b, err_b, ifb.in_ready);
    end
  endtask

  task automatic check_line(input string name, input bit sel, input string exp);
    string s;
    int    n, lead;
    bit    ok;
    send(sel, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL %s_handshake got=timeout exp=accept", name); end
    collect(sel, s, n, lead);
    checks++;
    if (s != exp) begin failures++; $display("FAIL %s_line got=\"%s\" exp=\"%s\"", name, s, exp); end
    checks++;
    if (n != exp.len() || lead != 0) begin
      failures++; $display("FAIL %s_timing got len=%0d lead=%0d exp len=%0d lead=0", name, n, lead, exp.len());
    end
    @(negedge clk);
    checks++;
    if (get_char(sel) !== 8'h20 || get_cv(sel) !== 1'b0) begin
      failures++; $display("FAIL %s_after got char=%h cv=%b exp 20 0", name, get_char(sel), get_cv(sel));
    end
  endtask

  task automatic test_reg_write;
    set_rec(0, 1'b0, 16'h0012, 32'h00003000, 5'd5, 32'h0, 32'h0000abcd);
    check_line("reg_sp1", 0, "^12@00003000: $5 <= 0000abcd#");
    set_rec(0, 1'b0, 16'h1234, 32'hdeadbeef, 5'd31, 32'h0, 32'h01234567);
    check_line("reg31_sp1", 0, "^1234@deadbeef: $31 <= 01234567#");
  endtask

  task automatic test_mem_write;
    set_rec(1, 1'b1, 16'h0000, 32'h00003004, 5'd31, 32'h00000010, 32'hffffffff);
    check_line("mem_sp0", 1, "^0@00003004:*00000010<=ffffffff#");
    set_rec(1, 1'b0, 16'h0100, 32'h00000001, 5'd10, 32'h0, 32'h0);
    check_line("reg10_sp0", 1, "^100@00000001:$10<=00000000#");
    set_rec(1, 1'b0, 16'h0009, 32'h0, 5'd9, 32'h0, 32'h0);
    check_line("reg9_sp0", 1, "^9@00000000:$9<=00000000#");
  endtask

  task automatic test_back_to_back;
    string s1, s2;
    int    n, lead, rdy_bad;
    bit    rdy_hash;
    s1 = "";
    rdy_bad = 0;
    rdy_hash = 1'b0;
    set_rec(0, 1'b0, 16'h0007, 32'h00000010, 5'd9, 32'h0, 32'hcafef00d);
    @(negedge clk);
    ifa.in_valid = 1'b1;
    @(posedge clk);
    #1;
    set_rec(0, 1'b1, 16'h9999, 32'hffffffff, 5'd0, 32'h80000000, 32'h00000000);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cv_a) s1 = $sformatf("%s%c", s1, char_a);
      if (ifa.in_ready) begin
        if (char_a == 8'h23) rdy_hash = 1'b1;
        else rdy_bad++;
      end
      if (char_a == 8'h23) break;
    end
    @(posedge clk);
    #1;
    ifa.in_valid = 1'b0;
    collect(0, s2, n, lead);
    checks++;
    if (s1 != "^7@00000010: $9 <= cafef00d#") begin failures++; $display("FAIL b2b_first got=\"%s\"", s1); end
    checks++;
    if (rdy_hash !== 1'b1 || rdy_bad != 0) begin
      failures++; $display("FAIL b2b_ready got hash=%b other=%0d exp hash=1 other=0", rdy_hash, rdy_bad);
    end
    checks++;
    if (lead != 0) begin failures++; $display("FAIL b2b_gap got=%0d idle cycles exp=0", lead); end
    checks++;
    if (s2 != "^9999@ffffffff: *80000000 <= 00000000#") begin failures++; $display("FAIL b2b_second got=\"%s\"", s2); end
    @(negedge clk);
  endtask

  task automatic test_bad_bcd;
    bit ok;
    int pulses, valids;
    set_rec(0, 1'b0, 16'h12a4, 32'h00000100, 5'd1, 32'h0, 32'h11111111);
    send(0, ok);
    @(negedge clk);
    checks++;
    if (err_a !== 1'b1 || char_a !== 8'h20 || cv_a !== 1'b0) begin
      failures++; $display("FAIL bad_bcd_first got err=%b char=%h cv=%b exp 1 20 0", err_a, char_a, cv_a);
    end
    pulses = 1;
    valids = 0;
    repeat (5) begin
      @(negedge clk);
      if (err_a) pulses++;
      if (cv_a || char_a != 8'h20) valids++;
    end
    checks++;
    if (pulses != 1 || valids != 0) begin
      failures++; $display("FAIL bad_bcd_pulse got extra_err=%0d chars=%0d exp 0 0", pulses - 1, valids);
    end
    set_rec(0, 1'b1, 16'h0050, 32'h0000000a, 5'd0, 32'h0000fffe, 32'h0);
    check_line("after_bad", 0, "^50@0000000a: *0000fffe <= 00000000#");
  endtask

  task automatic test_reset_mid;
    bit ok;
    int seen;
    set_rec(0, 1'b0, 16'h0012, 32'h00003000, 5'd5, 32'h0, 32'h0000abcd);
    send(0, ok);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (char_a !== 8'h20 || cv_a !== 1'b0 || ifa.in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_mid got char=%h cv=%b rdy=%b exp 20 0 1", char_a, cv_a, ifa.in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (cv_a) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL reset_mid_resume got=%0d chars exp=0", seen); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    ifa.in_valid = 1'b0;
    ifb.in_valid = 1'b0;
    set_rec(0, 1'b0, 16'h0, 32'h0, 5'd0, 32'h0, 32'h0);
    set_rec(1, 1'b0, 16'h0, 32'h0, 5'd0, 32'h0, 32'h0);
    test_reset();
    test_reg_write();
    test_mem_write();
    test_back_to_back();
    test_bad_bcd();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
